// File: rtl/kband_onchip_mem_dp.sv
// kband_onchip_mem_dp -- dual-port on-chip RAM for the KBand IP subsystem.
//
// Port A: Avalon-MM slave on the HPS lightweight bridge. Reads are pipelined
//   with s_readdatavalid. There is no waitrequest. Writes use byte enables.
//   A cycle with both s_read and s_write is treated as a write only.
// Port B: read-only burst streamer. b_start/b_base/b_len start a burst.
//   Words come out on b_data/b_valid with a b_ready handshake. b_busy covers
//   the whole burst. b_done pulses for one cycle when the burst completes.
// en = clken & ~reset_req. When en is low, neither port touches the RAM and
//   both read pipelines hold their state. Pops from the output FIFO continue.
//
// Optional macro KBAND_ONCHIP_MEM_OUTREG_EN adds an output register on both
//   RAM ports. Read latency L becomes 2 instead of 1, and the FIFO depth
//   becomes 3 instead of 2.
module kband_onchip_mem_dp #(
   parameter int    DATA_WIDTH = 32,
   parameter int    ADDR_WIDTH = 13,
   parameter int    DEPTH      = 8192,
   parameter int    LEN_WIDTH  = 14,
   parameter string INIT_FILE  = ""
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clken,
   input  logic                    reset_req,
   input  logic [ADDR_WIDTH-1:0]   s_address,
   input  logic                    s_chipselect,
   input  logic                    s_read,
   input  logic                    s_write,
   input  logic [DATA_WIDTH/8-1:0] s_byteenable,
   input  logic [DATA_WIDTH-1:0]   s_writedata,
   output logic [DATA_WIDTH-1:0]   s_readdata,
   output logic                    s_readdatavalid,
   input  logic                    b_start,
   input  logic [ADDR_WIDTH-1:0]   b_base,
   input  logic [LEN_WIDTH-1:0]    b_len,
   output logic                    b_busy,
   output logic                    b_done,
   output logic [DATA_WIDTH-1:0]   b_data,
   output logic                    b_valid,
   input  logic                    b_ready
);

`ifdef KBAND_ONCHIP_MEM_OUTREG_EN
   localparam int L = 2;
`else
   localparam int L = 1;
`endif
   localparam int FDEPTH = L + 1;
   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int PW     = $clog2(FDEPTH);
   localparam int CW     = $clog2(FDEPTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   logic en;
   assign en = clken & ~reset_req;

   // ---------------- RAM ----------------
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic a_wr, a_rd, b_rd;
   logic [ADDR_WIDTH-1:0] rd_addr;
   assign a_wr = s_chipselect & s_write & en;
   assign a_rd = s_chipselect & s_read & ~s_write & en;

   always_ff @(posedge clk)
      if (a_wr)
         for (int i = 0; i < NBYTES; i++)
            if (s_byteenable[i]) mem[s_address][i*8 +: 8] <= s_writedata[i*8 +: 8];

   // Read pipelines. Index L is the stage presented to the outside. Data
   // registers need no reset because every use of them is gated by a valid bit.
   logic [L:1]            a_vld, b_vld;
   logic [DATA_WIDTH-1:0] a_dat [1:L];
   logic [DATA_WIDTH-1:0] b_dat [1:L];

   // Nonblocking reads of mem give port B the old word when port A writes
   // the same address in the same cycle.
   always_ff @(posedge clk) begin
      if (a_rd) a_dat[1] <= mem[s_address];
      if (b_rd) b_dat[1] <= mem[rd_addr];
`ifdef KBAND_ONCHIP_MEM_OUTREG_EN
      if (en) begin
         a_dat[2] <= a_dat[1];
         b_dat[2] <= b_dat[1];
      end
`endif
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         a_vld <= '0;
         b_vld <= '0;
      end else if (en) begin
         a_vld[1] <= a_rd;
         b_vld[1] <= b_rd;
`ifdef KBAND_ONCHIP_MEM_OUTREG_EN
         a_vld[2] <= a_vld[1];
         b_vld[2] <= b_vld[1];
`endif
      end

   // While en is low, a finished read stays parked. It is shown when en returns.
   assign s_readdatavalid = a_vld[L] & en;
   assign s_readdata      = s_readdatavalid ? a_dat[L] : '0;

   // ---------------- output FIFO (show-ahead) ----------------
   logic [DATA_WIDTH-1:0] fifo [FDEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         fifo_cnt, inflight;
   logic                  push, pop, room;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign push    = en & b_vld[L];
   assign b_valid = (fifo_cnt != '0);
   assign pop     = b_valid & b_ready;
   assign b_data  = b_valid ? fifo[rd_ptr] : '0;

   always_comb begin
      inflight = '0;
      for (int k = 1; k <= L; k++) inflight = inflight + CW'(b_vld[k]);
   end

   // Issue credit: FIFO words plus reads in flight, after this cycle's pop,
   // must leave a free slot. This keeps the FIFO from ever overflowing.
   assign room = ({1'b0, fifo_cnt} + {1'b0, inflight} - {{CW{1'b0}}, pop})
                 < (CW+1)'(FDEPTH);

   always_ff @(posedge clk)
      if (push) fifo[wr_ptr] <= b_dat[L];

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      end

   // ---------------- port B burst FSM ----------------
   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] addr, addr_n;
   logic [LEN_WIDTH-1:0]  rem, rem_n;
   logic                  zero_done, drain_done;

   function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
      return (a == ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + 1'b1;
   endfunction

   always_comb begin
      state_n    = state;
      addr_n     = addr;
      rem_n      = rem;
      rd_addr    = addr;
      b_rd       = 1'b0;
      drain_done = 1'b0;
      unique case (state)
         IDLE:
            if (b_start && b_len != '0) begin
               state_n = RUN;
               addr_n  = b_base;
               rem_n   = b_len;
               // The first word is read in the start cycle itself. This lets
               // the stream begin L+1 cycles after b_start.
               if (en && room) begin
                  b_rd    = 1'b1;
                  rd_addr = b_base;
                  addr_n  = addr_inc(b_base);
                  rem_n   = b_len - 1'b1;
                  if (b_len == LEN_WIDTH'(1)) state_n = DRAIN;
               end
            end
         RUN:
            if (en && rem != '0 && room) begin
               b_rd   = 1'b1;
               addr_n = addr_inc(addr);
               rem_n  = rem - 1'b1;
               if (rem == LEN_WIDTH'(1)) state_n = DRAIN;
            end
         DRAIN:
            if (fifo_cnt == '0 && inflight == '0) begin
               drain_done = 1'b1;
               state_n    = IDLE;
            end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state     <= IDLE;
         addr      <= '0;
         rem       <= '0;
         zero_done <= 1'b0;
      end else begin
         state     <= state_n;
         addr      <= addr_n;
         rem       <= rem_n;
         zero_done <= (state == IDLE) & b_start & (b_len == '0);
      end

   // These outputs are decoded from asynchronously reset state, so reset
   // clears them at once without waiting for a clock edge.
   assign b_busy = (state != IDLE);
   assign b_done = drain_done | zero_done;

endmodule
